// File: rtl/pixel_feeder.sv
// pixel_feeder: fetches 24-bit pixels and paces them to a WS281x-style serializer,
// one load strobe per WORD_CYCLES, followed by a latch gap.
module pixel_feeder #(
  parameter int NUM_LEDS     = 8,
  parameter int WORD_CYCLES  = 744,
  parameter int LATCH_CYCLES = 2500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic [23:0] data,
  output logic        slowclk,
  output logic        ws_rst,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);
  localparam int WW = $clog2(WORD_CYCLES);
  localparam int PW = $clog2(NUM_LEDS + 1);
  localparam int LW = $clog2(LATCH_CYCLES);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, LATCH} state_t;
  state_t state, next;
  logic [WW-1:0] wc;
  logic [PW-1:0] pc;
  logic [LW-1:0] lc;
  logic last, shift_done, latch_done;
  // the last word shifts one extra cycle, standing in for the FETCH slot, so the latch strobe keeps the word spacing
  assign last       = pc >= PW'(NUM_LEDS);
  assign shift_done = wc == (last ? WW'(WORD_CYCLES - 2) : WW'(WORD_CYCLES - 3));
  assign latch_done = lc == LW'(LATCH_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      data     <= '0;
      underrun <= 1'b0;
      wc       <= '0;
      pc       <= '0;
      lc       <= '0;
    end else begin
      state <= next;
      if (state == IDLE && start) begin
        underrun <= 1'b0;
        pc       <= '0;
      end
      if (state == FETCH) begin
        data <= pix_valid ? pix_data : 24'h0;
        if (!pix_valid) underrun <= 1'b1;
      end
      if (state == LOAD) begin
        wc <= '0;
        pc <= pc + PW'(1);
      end
      if (state == SHIFT) begin
        wc <= wc + WW'(1);
        lc <= '0;
      end
      if (state == LATCH) lc <= latch_done ? '0 : lc + LW'(1);
    end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? FETCH : IDLE;
      FETCH:   next = LOAD;
      LOAD:    next = SHIFT;
      SHIFT:   next = shift_done ? (last ? LATCH : FETCH) : SHIFT;
      LATCH:   next = latch_done ? IDLE : LATCH;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    pix_ready  = state == FETCH;
    slowclk    = state == LOAD || (state == LATCH && lc == '0);
    ws_rst     = state == LATCH;
    busy       = state != IDLE;
    frame_done = state == LATCH && latch_done;
  end
endmodule

// File: tb/tb_pixel_feeder.sv
// tb_pixel_feeder: directed checks of frame timing, underrun, start filtering and reset,
// on a small 3/8/20 instance and a default-parameter single-LED instance.
module tb_pixel_feeder;
  logic clk = 0, rst, start, start2, pix_valid;
  logic [23:0] pix_data;
  logic pix_ready, slowclk, ws_rst, busy, frame_done, underrun;
  logic [23:0] data;
  logic pix_ready2, slowclk2, ws_rst2, busy2, frame_done2, underrun2;
  logic [23:0] data2;
  int cnt = 0, bad = 0;

  always #5 clk = ~clk;

  pixel_feeder #(.NUM_LEDS(3), .WORD_CYCLES(8), .LATCH_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .data(data), .slowclk(slowclk), .ws_rst(ws_rst),
    .busy(busy), .frame_done(frame_done), .underrun(underrun));

  pixel_feeder #(.NUM_LEDS(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready2), .data(data2), .slowclk(slowclk2), .ws_rst(ws_rst2),
    .busy(busy2), .frame_done(frame_done2), .underrun(underrun2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cnt++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, {pix_ready, slowclk, ws_rst, busy, frame_done, underrun}, 0);
    chk({tag, "_data"}, data, 0);
  endtask

  // start is taken in cycle 0; relative cycle i is checked mid-cycle
  task automatic run_frame(input bit drop, input bit extra, input bit prev_ur);
    @(negedge clk);
    start = 1; pix_valid = 1; pix_data = 24'hA5A5A5;
    chk("idle_busy", busy, 0);
    chk("idle_underrun", underrun, prev_ur);
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      start = extra && (i == 5 || i == 45);
      pix_data = i < 9 ? 24'hA5A5A5 : i < 17 ? 24'h00FF00 : 24'hFFFFFF;
      pix_valid = !(drop && i == 9);
      chk($sformatf("slowclk@%0d", i), slowclk, i == 2 || i == 10 || i == 18 || i == 26);
      chk($sformatf("ws_rst@%0d", i), ws_rst, i >= 26);
      chk($sformatf("frame_done@%0d", i), frame_done, i == 45);
      chk($sformatf("busy@%0d", i), busy, 1);
      chk($sformatf("pix_ready@%0d", i), pix_ready, i == 1 || i == 9 || i == 17);
      chk($sformatf("underrun@%0d", i), underrun, drop && i >= 10);
      if (i == 2) chk("word1", data, 24'hA5A5A5);
      if (i == 10) chk("word2", data, drop ? 24'h0 : 24'h00FF00);
      if (i == 18) chk("word3", data, 24'hFFFFFF);
      if (i == 26) chk("latch_data", data, 24'hFFFFFF);
    end
  endtask

  initial begin
    logic stray;
    int sc, first_sc, second_sc, ws_cnt, fd_at;
    rst = 1; start = 0; start2 = 0; pix_valid = 1; pix_data = 24'h123456;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 0;

    run_frame(0, 0, 0);
    run_frame(1, 1, 0);
    run_frame(0, 0, 1);

    @(negedge clk);
    start = 1; pix_valid = 1; pix_data = 24'hA5A5A5;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start = 0;
      pix_data = i < 9 ? 24'hA5A5A5 : 24'h00FF00;
    end
    chk("pre_rst_busy", busy, 1);
    rst = 1;
    #1 chk_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    chk_reset_outputs("held_rst");
    rst = 0;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      stray |= slowclk | frame_done | busy | ws_rst;
    end
    chk("post_rst_quiet", stray, 0);
    run_frame(0, 0, 0);

    @(negedge clk);
    start2 = 1; pix_valid = 1; pix_data = 24'h123456;
    sc = 0; first_sc = -1; second_sc = -1; ws_cnt = 0; fd_at = -1;
    for (int i = 1; i <= 3300; i++) begin
      @(negedge clk);
      start2 = 0;
      if (slowclk2) begin
        sc++;
        if (sc == 1) begin
          first_sc = i;
          chk("n1_word", data2, 24'h123456);
        end
        if (sc == 2) second_sc = i;
      end
      if (ws_rst2) ws_cnt++;
      if (frame_done2 && fd_at < 0) fd_at = i;
    end
    chk("n1_first_slowclk", first_sc, 2);
    chk("n1_latch_slowclk", second_sc, 746);
    chk("n1_slowclk_count", sc, 2);
    chk("n1_ws_rst_len", ws_cnt, 2500);
    chk("n1_frame_done", fd_at, 3245);
    chk("n1_idle_after", busy2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, bad);
    $finish;
  end
endmodule
